// File: rtl/riscv_mem_pkg.sv
// Shared data-memory definitions: access-size and FSM encodings plus the
// byte-lane select helper used by the lane aligner.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_X = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // Byte-enable mask for an access of the given size at byte offset addr_lo.
    function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SIZE_B: be = 4'b0001 << addr_lo;
            SIZE_H: begin
                if (addr_lo[1]) begin
                    be = 4'b1100;
                end else begin
                    be = 4'b0011;
                end
            end
            SIZE_W: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane handling: load extract/extend, store merge into the
// current word, and misalignment / illegal-size detection.
module dmem_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] word,
    output logic [31:0] load_data,
    output logic [31:0] store_word,
    output logic        misaligned
);

    logic [31:0] shifted_s;
    logic [15:0] half_s;
    logic [31:0] rep_s;
    logic [3:0]  be_s;

    // Alignment check: halves need even addresses, words need 4-byte alignment.
    always_comb begin
        misaligned = 1'b0;
        case (size)
            SIZE_B:  misaligned = 1'b0;
            SIZE_H:  misaligned = addr_lo[0];
            SIZE_W:  misaligned = (addr_lo != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // Load path: pick the addressed lane and extend to 32 bits.
    always_comb begin
        shifted_s = word >> {addr_lo, 3'b000};
        if (addr_lo[1]) begin
            half_s = word[31:16];
        end else begin
            half_s = word[15:0];
        end
        load_data = 32'd0;
        case (size)
            SIZE_B: begin
                if (is_unsigned) begin
                    load_data = {24'd0, shifted_s[7:0]};
                end else begin
                    load_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
                end
            end
            SIZE_H: begin
                if (is_unsigned) begin
                    load_data = {16'd0, half_s};
                end else begin
                    load_data = {{16{half_s[15]}}, half_s};
                end
            end
            SIZE_W:  load_data = word;
            default: load_data = 32'd0;
        endcase
    end

    // Store path: replicate right-aligned data across lanes, then keep only enabled bytes.
    always_comb begin
        be_s  = lane_sel(size, addr_lo);
        rep_s = wdata;
        case (size)
            SIZE_B:  rep_s = {4{wdata[7:0]}};
            SIZE_H:  rep_s = {2{wdata[15:0]}};
            SIZE_W:  rep_s = wdata;
            default: rep_s = wdata;
        endcase
        store_word = word;
        for (int i = 0; i < 4; i++) begin
            if (be_s[i]) begin
                store_word[8*i +: 8] = rep_s[8*i +: 8];
            end else begin
                store_word[8*i +: 8] = word[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: single outstanding request, fixed access latency,
// read-modify-write stores committed at the end of the response cycle.
module dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         DEPTH    = 2 ** ADDR_W;
    localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);

    state_e             state_r;
    state_e             state_nxt_s;
    logic [3:0]         cnt_r;
    logic               we_r;
    logic               uns_r;
    logic [1:0]         size_r;
    logic [1:0]         lo_r;
    logic [ADDR_W-1:0]  idx_r;
    logic [31:0]        wdata_r;
    logic [31:0]        mem_r [DEPTH];

    logic               req_ready_r;
    logic               resp_valid_r;
    logic [31:0]        resp_rdata_r;
    logic               resp_err_r;

    logic               accept_s;
    logic               enter_resp_s;
    logic               commit_s;
    logic               sel_we_s;
    logic               sel_uns_s;
    logic [1:0]         sel_size_s;
    logic [1:0]         sel_lo_s;
    logic [ADDR_W-1:0]  sel_idx_s;
    logic [31:0]        sel_wdata_s;
    logic [31:0]        word_s;
    logic [31:0]        load_data_s;
    logic [31:0]        store_word_s;
    logic               misaligned_s;

    // In IDLE the aligner sees the live request so a 1-cycle latency can capture load data at accept.
    always_comb begin
        if (state_r == ST_IDLE) begin
            sel_we_s    = req_we;
            sel_uns_s   = req_unsigned;
            sel_size_s  = req_size;
            sel_lo_s    = req_addr[1:0];
            sel_idx_s   = req_addr[ADDR_W+1:2];
            sel_wdata_s = req_wdata;
        end else begin
            sel_we_s    = we_r;
            sel_uns_s   = uns_r;
            sel_size_s  = size_r;
            sel_lo_s    = lo_r;
            sel_idx_s   = idx_r;
            sel_wdata_s = wdata_r;
        end
        word_s = mem_r[sel_idx_s];
    end

    dmem_lane_align u_align (
        .size        (sel_size_s),
        .addr_lo     (sel_lo_s),
        .is_unsigned (sel_uns_s),
        .wdata       (sel_wdata_s),
        .word        (word_s),
        .load_data   (load_data_s),
        .store_word  (store_word_s),
        .misaligned  (misaligned_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; cnt counts completed WAIT cycles including the current one.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        state_nxt_s = ST_RESP;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if ((cnt_r + 4'd1) == LAST_CNT) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output/control decode from the current and next state.
    always_comb begin
        accept_s     = req_valid && (state_r == ST_IDLE);
        enter_resp_s = (state_nxt_s == ST_RESP) && (state_r != ST_RESP);
        commit_s     = (state_r == ST_RESP) && we_r && !resp_err_r;
    end

    // Request latch and latency counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= 4'd0;
            we_r    <= 1'b0;
            uns_r   <= 1'b0;
            size_r  <= 2'b00;
            lo_r    <= 2'b00;
            idx_r   <= '0;
            wdata_r <= 32'd0;
        end else if (accept_s) begin
            cnt_r   <= 4'd0;
            we_r    <= req_we;
            uns_r   <= req_unsigned;
            size_r  <= req_size;
            lo_r    <= req_addr[1:0];
            idx_r   <= req_addr[ADDR_W+1:2];
            wdata_r <= req_wdata;
        end else if (state_r == ST_WAIT) begin
            cnt_r <= cnt_r + 4'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Registered handshake and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'd0;
            resp_err_r   <= 1'b0;
        end else begin
            req_ready_r  <= (state_nxt_s == ST_IDLE);
            resp_valid_r <= (state_nxt_s == ST_RESP);
            if (enter_resp_s) begin
                resp_err_r <= misaligned_s;
                if (misaligned_s || sel_we_s) begin
                    resp_rdata_r <= 32'd0;
                end else begin
                    resp_rdata_r <= load_data_s;
                end
            end else if (state_r == ST_RESP) begin
                resp_err_r   <= 1'b0;
                resp_rdata_r <= 32'd0;
            end else begin
                resp_err_r   <= resp_err_r;
                resp_rdata_r <= resp_rdata_r;
            end
        end
    end

    // Store commit at the end of RESP; a reset in RESP drops the write.
    always_ff @(posedge clk) begin
        if (commit_s && !rst) begin
            mem_r[idx_r] <= store_word_s;
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a LATENCY=2 and a LATENCY=1 instance,
// table-driven requests with a response scoreboard plus reset corner sequences.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_valid1;
    logic        req_we;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        req_ready1, resp_valid1, resp_err1;
    logic [31:0] resp_rdata1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] er;
        logic        ee;
    } vec_t;

    exp_t q0[$];
    exp_t q1[$];
    vec_t vt[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.ADDR_W(10), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_responder #(.ADDR_W(10), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .resp_valid(resp_valid1), .resp_rdata(resp_rdata1), .resp_err(resp_err1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard for the LATENCY=2 instance.
    always @(negedge clk) begin : mon0
        exp_t e;
        if (resp_valid === 1'b1) begin
            if (q0.size() == 0) begin
                chk("unexpected_resp0", 32'd1, 32'd0);
            end else begin
                e = q0.pop_front();
                chk("rdata0", resp_rdata, e.rdata);
                chk("err0", {31'd0, resp_err}, {31'd0, e.err});
                chk("latency0", 32'(cyc + 1 - e.acc), 32'd2);
            end
        end
    end

    // Scoreboard for the LATENCY=1 instance.
    always @(negedge clk) begin : mon1
        exp_t e;
        if (resp_valid1 === 1'b1) begin
            if (q1.size() == 0) begin
                chk("unexpected_resp1", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                chk("rdata1", resp_rdata1, e.rdata);
                chk("err1", {31'd0, resp_err1}, {31'd0, e.err});
                chk("latency1", 32'(cyc + 1 - e.acc), 32'd1);
            end
        end
    end

    task automatic issue(input int sel, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                         input logic push, input logic [31:0] er, input logic ee);
        int   guard;
        exp_t e;
        @(negedge clk);
        req_we       = we;
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = size;
        req_unsigned = uns;
        if (sel == 0) req_valid = 1'b1;
        else          req_valid1 = 1'b1;
        guard = 0;
        while ((((sel == 0) ? req_ready : req_ready1) !== 1'b1) && (guard < 20)) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) begin
            chk("accept_timeout", 32'(guard), 32'd0);
            req_valid  = 1'b0;
            req_valid1 = 1'b0;
        end else begin
            if (push) begin
                e.rdata = er;
                e.err   = ee;
                e.acc   = cyc + 1;
                if (sel == 0) q0.push_back(e);
                else          q1.push_back(e);
            end
            @(posedge clk);
            #1;
            req_valid  = 1'b0;
            req_valid1 = 1'b0;
        end
    endtask

    task automatic wait_drain(input int sel);
        int guard;
        guard = 0;
        while ((((sel == 0) ? q0.size() : q1.size()) != 0) && (guard < 20)) begin
            @(posedge clk);
            guard++;
        end
        if (guard >= 20) begin
            chk("resp_timeout", 32'(guard), 32'd0);
            q0.delete();
            q1.delete();
        end
    endtask

    task automatic do_req(input int sel, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                          input logic [31:0] er, input logic ee);
        issue(sel, we, addr, wdata, size, uns, 1'b1, er, ee);
        wait_drain(sel);
    endtask

    // Store whose response is seen, but with rst asserted during RESP so the write is dropped.
    task automatic rst_in_resp(input int sel, input logic [31:0] addr, input logic [31:0] wdata);
        int guard;
        issue(sel, 1'b1, addr, wdata, 2'b10, 1'b0, 1'b1, 32'd0, 1'b0);
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while ((((sel == 0) ? resp_valid : resp_valid1) !== 1'b1) && (guard < 20));
        if (guard >= 20) chk("resp_wait_timeout", 32'(guard), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_drain(sel);
    endtask

    task automatic add(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns, input logic [31:0] er, input logic ee);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.size = size;
        v.uns = uns; v.er = er; v.ee = ee;
        vt.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_valid1 = 1'b0; req_we = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; req_size = 2'b00; req_unsigned = 1'b0;

        // Table of {we, addr, wdata, size, unsigned, expected rdata, expected err}.
        add(1'b1, 32'h10,   32'hDEADBEEF, 2'b10, 1'b0, 32'h0,        1'b0);
        add(1'b0, 32'h10,   32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 1'b0);
        add(1'b1, 32'h20,   32'h11223344, 2'b10, 1'b0, 32'h0,        1'b0);
        add(1'b1, 32'h21,   32'hFFFFFF80, 2'b00, 1'b0, 32'h0,        1'b0);
        add(1'b0, 32'h21,   32'h0,        2'b00, 1'b0, 32'hFFFFFF80, 1'b0);
        add(1'b0, 32'h21,   32'h0,        2'b00, 1'b1, 32'h00000080, 1'b0);
        add(1'b0, 32'h20,   32'h0,        2'b10, 1'b0, 32'h11228044, 1'b0);
        add(1'b0, 32'h22,   32'h0,        2'b01, 1'b0, 32'h00001122, 1'b0);
        add(1'b0, 32'h20,   32'h0,        2'b01, 1'b0, 32'hFFFF8044, 1'b0);
        add(1'b0, 32'h20,   32'h0,        2'b01, 1'b1, 32'h00008044, 1'b0);
        add(1'b1, 32'h12,   32'h0000A5A5, 2'b01, 1'b0, 32'h0,        1'b0);
        add(1'b0, 32'h13,   32'h0,        2'b00, 1'b0, 32'hFFFFFFA5, 1'b0);
        add(1'b0, 32'h10,   32'h0,        2'b00, 1'b1, 32'h000000EF, 1'b0);
        add(1'b0, 32'h10,   32'h0,        2'b10, 1'b0, 32'hA5A5BEEF, 1'b0);
        add(1'b1, 32'h00,   32'hCAFEF00D, 2'b10, 1'b0, 32'h0,        1'b0);
        add(1'b1, 32'h03,   32'h0000BEEF, 2'b01, 1'b0, 32'h0,        1'b1);
        add(1'b0, 32'h00,   32'h0,        2'b10, 1'b0, 32'hCAFEF00D, 1'b0);
        add(1'b0, 32'h22,   32'h0,        2'b10, 1'b0, 32'h0,        1'b1);
        add(1'b1, 32'h20,   32'hFFFFFFFF, 2'b11, 1'b0, 32'h0,        1'b1);
        add(1'b0, 32'h24,   32'h0,        2'b11, 1'b0, 32'h0,        1'b1);
        add(1'b0, 32'h20,   32'h0,        2'b10, 1'b0, 32'h11228044, 1'b0);
        add(1'b1, 32'h1000, 32'h12345678, 2'b10, 1'b0, 32'h0,        1'b0);
        add(1'b0, 32'h0000, 32'h0,        2'b10, 1'b0, 32'h12345678, 1'b0);
        add(1'b1, 32'h40,   32'h01020304, 2'b10, 1'b0, 32'h0,        1'b0);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready0", {31'd0, req_ready}, 32'd1);
        chk("rst_valid0", {31'd0, resp_valid}, 32'd0);
        chk("rst_rdata0", resp_rdata, 32'd0);
        chk("rst_err0", {31'd0, resp_err}, 32'd0);
        chk("rst_ready1", {31'd0, req_ready1}, 32'd1);
        chk("rst_valid1", {31'd0, resp_valid1}, 32'd0);

        for (int i = 0; i < vt.size(); i++) begin
            do_req(0, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].size, vt[i].uns, vt[i].er, vt[i].ee);
        end

        // Reset while in WAIT: no response, no write.
        issue(0, 1'b1, 32'h40, 32'hAAAA5555, 2'b10, 1'b0, 1'b0, 32'd0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_wait_rst", {31'd0, req_ready}, 32'd1);
        repeat (4) @(posedge clk);
        do_req(0, 1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 32'h01020304, 1'b0);

        // Reset while in RESP: response seen, store suppressed.
        rst_in_resp(0, 32'h40, 32'hBBBBBBBB);
        do_req(0, 1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 32'h01020304, 1'b0);

        // LATENCY=1 instance.
        do_req(1, 1'b1, 32'h40, 32'hAAAA5555, 2'b10, 1'b0, 32'h0, 1'b0);
        do_req(1, 1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 32'hAAAA5555, 1'b0);
        do_req(1, 1'b0, 32'h43, 32'h0, 2'b00, 1'b0, 32'hFFFFFFAA, 1'b0);
        rst_in_resp(1, 32'h40, 32'h5555AAAA);
        do_req(1, 1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 32'hAAAA5555, 1'b0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
